// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares one FIFO write port between two producers. Round-robin arbitration
//   with bounded bursts: a granted producer may write at most MAX_BURST words
//   before the grant is re-evaluated. Never writes into a full FIFO; a full
//   FIFO stalls the current grant without consuming burst budget.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req0/din0/ack0    producer 0 handshake: req held until ack
//   req1/din1/ack1    producer 1 handshake
//   fifo_full         FIFO full flag (combinational in the FIFO)
//   fifo_over         FIFO overflow flag, monitored for err
//   fifo_wr/fifo_din  FIFO write strobe and data
//   gnt               registered one-hot grant, 2'b00 = idle
//   err               sticky: fifo_over seen while a grant is active
//
// Optional feature: define ARB_STATS_EN to add wcnt0/wcnt1, saturating
// per-producer accepted-word counters of width STAT_W.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DW        = 16,
  parameter int MAX_BURST = 4,
  parameter int CW        = 3
`ifdef ARB_STATS_EN
  , parameter int STAT_W  = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] din0,
  output logic          ack0,
  input  logic          req1,
  input  logic [DW-1:0] din1,
  output logic          ack1,
  input  logic          fifo_full,
  input  logic          fifo_over,
  output logic          fifo_wr,
  output logic [DW-1:0] fifo_din,
  output logic [1:0]    gnt,
  output logic          err
`ifdef ARB_STATS_EN
  , output logic [STAT_W-1:0] wcnt0,
  output logic [STAT_W-1:0] wcnt1
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

  // Burst counter value at which the current write is the last of the burst.
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rr_q, rr_d;
  logic            err_q, err_d;

  logic            own_req_s;
  logic            oth_req_s;
  logic            cur_idx_s;
  logic            at_last_s;
  logic            leave_s;
  logic            wr_s;

  // Write gating: only the granted producer's request can reach the FIFO.
  always_comb begin
    own_req_s = 1'b0;
    if (gnt_q[1]) begin
      own_req_s = req1;
    end else if (gnt_q[0]) begin
      own_req_s = req0;
    end else begin
      own_req_s = 1'b0;
    end
    // rst is folded in so a reset cycle never completes a write.
    wr_s = ~rst & own_req_s & ~fifo_full;
  end

  assign fifo_wr  = wr_s;
  assign ack0     = wr_s & gnt_q[0];
  assign ack1     = wr_s & gnt_q[1];
  assign fifo_din = gnt_q[1] ? din1 : din0;
  assign gnt      = gnt_q;
  assign err      = err_q;

  // Next-state, burst counter, round-robin pointer and sticky error.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    cur_idx_s = 1'b0;
    oth_req_s = 1'b0;
    at_last_s = 1'b0;
    leave_s   = 1'b0;
    err_d     = err_q | (fifo_over & (gnt_q != 2'b00));

    case (state_q)
      ST_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (req0 & req1) begin
          state_d = rr_q ? ST_G1 : ST_G0;
        end else if (req0) begin
          state_d = ST_G0;
        end else if (req1) begin
          state_d = ST_G1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_G0, ST_G1: begin
        cur_idx_s = (state_q == ST_G1);
        oth_req_s = cur_idx_s ? req0 : req1;
        at_last_s = (cnt_q == LAST);
        // A full-FIFO stall keeps wr_s low, so it neither counts nor ends the burst.
        leave_s   = ~own_req_s | (at_last_s & wr_s);
        if (leave_s) begin
          rr_d  = ~cur_idx_s;
          cnt_d = {CW{1'b0}};
          if (oth_req_s) begin
            state_d = cur_idx_s ? ST_G0 : ST_G1;
          end else if (own_req_s) begin
            state_d = state_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (wr_s) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
        rr_d    = 1'b0;
      end
    endcase

    // The grant register mirrors the state it is about to enter.
    case (state_d)
      ST_G0:   gnt_d = 2'b01;
      ST_G1:   gnt_d = 2'b10;
      default: gnt_d = 2'b00;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      cnt_q   <= {CW{1'b0}};
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] wcnt0_q, wcnt0_d;
  logic [STAT_W-1:0] wcnt1_q, wcnt1_d;

  // Saturating accepted-word counters.
  always_comb begin
    if (ack0 && (wcnt0_q != {STAT_W{1'b1}})) begin
      wcnt0_d = wcnt0_q + STAT_W'(1);
    end else begin
      wcnt0_d = wcnt0_q;
    end
    if (ack1 && (wcnt1_q != {STAT_W{1'b1}})) begin
      wcnt1_d = wcnt1_q + STAT_W'(1);
    end else begin
      wcnt1_d = wcnt1_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt0_q <= {STAT_W{1'b0}};
      wcnt1_q <= {STAT_W{1'b0}};
    end else begin
      wcnt0_q <= wcnt0_d;
      wcnt1_q <= wcnt1_d;
    end
  end

  assign wcnt0 = wcnt0_q;
  assign wcnt1 = wcnt1_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a cycle table for gating/arbitration basics, then
// producer + FIFO-occupancy sequences for bursts, contention, full stall,
// reset mid-burst, MAX_BURST=1 alternation and the sticky error flag.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst, req0, req1, fifo_full, fifo_over;
  logic [15:0] din0, din1;

  logic        a_ack0, a_ack1, a_wr, a_err;
  logic [15:0] a_din;
  logic [1:0]  a_gnt;
  logic        b_ack0, b_ack1, b_wr, b_err;
  logic [15:0] b_din;
  logic [1:0]  b_gnt;
`ifdef ARB_STATS_EN
  logic [15:0] a_wc0, a_wc1, b_wc0, b_wc1;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DW(16), .MAX_BURST(4), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .ack0(a_ack0),
    .req1(req1), .din1(din1), .ack1(a_ack1),
    .fifo_full(fifo_full), .fifo_over(fifo_over),
    .fifo_wr(a_wr), .fifo_din(a_din), .gnt(a_gnt), .err(a_err)
`ifdef ARB_STATS_EN
    , .wcnt0(a_wc0), .wcnt1(a_wc1)
`endif
  );

  fifo_wr_arbiter #(.DW(16), .MAX_BURST(1), .CW(3)) dut1 (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .ack0(b_ack0),
    .req1(req1), .din1(din1), .ack1(b_ack1),
    .fifo_full(fifo_full), .fifo_over(fifo_over),
    .fifo_wr(b_wr), .fifo_din(b_din), .gnt(b_gnt), .err(b_err)
`ifdef ARB_STATS_EN
    , .wcnt0(b_wc0), .wcnt1(b_wc1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        rst, r0, r1;
    logic [15:0] d0, d1;
    logic        full, over;
    logic [1:0]  gnt;
    logic        wr, a0, a1;
    logic [15:0] dout;
    logic        err;
  } vec_t;
  vec_t tbl[14];

  // ---------------- sequence model state ----------------
  logic [15:0] w0[$], w1[$];
  int          i0, i1, start1, sel, fifo_cnt, drain_cyc, rst_cyc;
  bit          auto_pop, both_ack, wr_full, bad_ack;
  int          lg_src[$], lg_cyc[$], exp_src[$];
  logic [15:0] lg_dat[$], exp_dat[$];
  logic [1:0]  gnt_log[64];
  logic        wr_log[64];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fifo_full = 1'b0; fifo_over = 1'b0;
    din0 = 16'h0; din1 = 16'h0;
    @(posedge clk);
  endtask

  task automatic clear_log();
    lg_src.delete(); lg_cyc.delete(); lg_dat.delete();
    exp_src.delete(); exp_dat.delete();
    both_ack = 1'b0; wr_full = 1'b0; bad_ack = 1'b0;
    for (int k = 0; k < 64; k++) begin
      gnt_log[k] = 2'bxx; wr_log[k] = 1'bx;
    end
  endtask

  task automatic setup();
    w0.delete(); w1.delete();
    i0 = 0; i1 = 0; start1 = 0; sel = 0; fifo_cnt = 0;
    drain_cyc = -1; rst_cyc = -1; auto_pop = 1'b0;
    clear_log();
    do_reset();
  endtask

  // Drives producers and FIFO flags one cycle at a time and logs writes.
  task automatic run(input int max_cyc, input bit fixed, input string nm);
    int c = 0;
    logic [1:0]  g;
    logic        wr, a0, a1;
    logic [15:0] d;
    while (c < max_cyc && (fixed || i0 < w0.size() || i1 < w1.size())) begin
      @(negedge clk);
      rst       = (c == rst_cyc);
      req0      = (i0 < w0.size());
      din0      = req0 ? w0[i0] : 16'h0;
      req1      = (c >= start1) && (i1 < w1.size());
      din1      = req1 ? w1[i1] : 16'h0;
      fifo_full = (fifo_cnt >= 8);
      fifo_over = 1'b0;
      #1;
      if (sel == 0) begin
        g = a_gnt; wr = a_wr; a0 = a_ack0; a1 = a_ack1; d = a_din;
      end else begin
        g = b_gnt; wr = b_wr; a0 = b_ack0; a1 = b_ack1; d = b_din;
      end
      if (c < 64) begin
        gnt_log[c] = g; wr_log[c] = wr;
      end
      if (a0 && a1) both_ack = 1'b1;
      if (wr && fifo_full) wr_full = 1'b1;
      if (wr != (a0 | a1)) bad_ack = 1'b1;
      if (wr) begin
        lg_src.push_back(a1 ? 1 : 0); lg_dat.push_back(d); lg_cyc.push_back(c);
        fifo_cnt++;
      end
      if (a0) i0++;
      if (a1) i1++;
      if (auto_pop && fifo_cnt > 0) fifo_cnt--;
      if (c == drain_cyc) fifo_cnt -= 2;
      c++;
    end
    if (!fixed) check({nm, " completes"}, 32'((i0 >= w0.size()) && (i1 >= w1.size())), 32'd1);
  endtask

  task automatic cmp_log(input string nm);
    check({nm, " count"}, 32'(lg_dat.size()), 32'(exp_dat.size()));
    for (int k = 0; k < exp_dat.size(); k++) begin
      if (k < lg_dat.size()) begin
        check($sformatf("%s src%0d", nm, k), 32'(lg_src[k]), 32'(exp_src[k]));
        check($sformatf("%s data%0d", nm, k), 32'(lg_dat[k]), 32'(exp_dat[k]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    int          k0, k1;

    //          rst  r0   r1   d0        d1        full over  gnt    wr   a0   a1   dout      err
    tbl[0]  = '{1'b1,1'b1,1'b1,16'hA000,16'hB000,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,16'hA000,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,16'hA001,16'hB001,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,16'hA001,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b1,16'hA002,16'hB002,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,16'hA002,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b1,16'hA003,16'hB003,1'b1,1'b0, 2'b10, 1'b0,1'b0,1'b0,16'hB003,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b1,16'hA004,16'hB004,1'b0,1'b0, 2'b10, 1'b1,1'b0,1'b1,16'hB004,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,16'hA005,16'hB005,1'b0,1'b0, 2'b10, 1'b0,1'b0,1'b0,16'hB005,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b1,16'hA006,16'hB006,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,16'hA006,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b1,16'hA007,16'hB007,1'b0,1'b0, 2'b01, 1'b1,1'b1,1'b0,16'hA007,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b1,16'hA008,16'hB008,1'b0,1'b0, 2'b01, 1'b0,1'b0,1'b0,16'hA008,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,16'hA009,16'hB009,1'b0,1'b1, 2'b10, 1'b1,1'b0,1'b1,16'hB009,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,16'hA00A,16'hB00A,1'b0,1'b0, 2'b10, 1'b0,1'b0,1'b0,16'hB00A,1'b1};
    tbl[11] = '{1'b1,1'b1,1'b0,16'hA00B,16'hB00B,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,16'hA00B,1'b1};
    tbl[12] = '{1'b0,1'b0,1'b0,16'hA00C,16'hB00C,1'b0,1'b1, 2'b00, 1'b0,1'b0,1'b0,16'hA00C,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,16'hA00D,16'hB00D,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,16'hA00D,1'b0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
      din0 = tbl[i].d0; din1 = tbl[i].d1;
      fifo_full = tbl[i].full; fifo_over = tbl[i].over;
      #1;
      check($sformatf("vec%0d gnt", i),  32'(a_gnt),  32'(tbl[i].gnt));
      check($sformatf("vec%0d wr", i),   32'(a_wr),   32'(tbl[i].wr));
      check($sformatf("vec%0d ack0", i), 32'(a_ack0), 32'(tbl[i].a0));
      check($sformatf("vec%0d ack1", i), 32'(a_ack1), 32'(tbl[i].a1));
      check($sformatf("vec%0d din", i),  32'(a_din),  32'(tbl[i].dout));
      check($sformatf("vec%0d err", i),  32'(a_err),  32'(tbl[i].err));
    end

    // T1: single producer, 5 words, burst limit 4 with re-grant to itself.
    setup();
    for (int k = 0; k < 5; k++) begin
      w0.push_back(16'hA100 + 16'(k));
      exp_src.push_back(0); exp_dat.push_back(16'hA100 + 16'(k));
    end
    run(40, 1'b0, "T1");
    cmp_log("T1");
    check("T1 gnt c0", 32'(gnt_log[0]), 32'h0);
    check("T1 gnt c1", 32'(gnt_log[1]), 32'h1);
    check("T1 gnt c5", 32'(gnt_log[5]), 32'h1);
    if (lg_cyc.size() == 5) begin
      check("T1 first write cycle", 32'(lg_cyc[0]), 32'd1);
      check("T1 A4 write cycle", 32'(lg_cyc[4]), 32'd5);
    end else begin
      check("T1 write cycles", 32'(lg_cyc.size()), 32'd5);
    end

    // T2: contention, 6 words each: 4x p0, 4x p1, 2x p0, 2x p1.
    setup();
    auto_pop = 1'b1;
    pat = 12'b0000_1111_0011;
    k0 = 0; k1 = 0;
    for (int k = 0; k < 6; k++) begin
      w0.push_back(16'hC000 + 16'(k));
      w1.push_back(16'hD000 + 16'(k));
    end
    for (int k = 0; k < 12; k++) begin
      exp_src.push_back(int'(pat[11-k]));
      if (pat[11-k]) begin
        exp_dat.push_back(16'hD000 + 16'(k1)); k1++;
      end else begin
        exp_dat.push_back(16'hC000 + 16'(k0)); k0++;
      end
    end
    run(80, 1'b0, "T2");
    cmp_log("T2");
    check("T2 gnt c1", 32'(gnt_log[1]), 32'h1);
    check("T2 ack0&ack1 never", 32'(both_ack), 32'd0);
    check("T2 ack matches wr", 32'(bad_ack), 32'd0);
`ifdef ARB_STATS_EN
    check("T2 wcnt0", 32'(a_wc0), 32'd6);
    check("T2 wcnt1", 32'(a_wc1), 32'd6);
`endif

    // T3: FIFO holds 7, producer 1 has 3 words, 2 words drained at cycle 5.
    setup();
    fifo_cnt = 7;
    drain_cyc = 5;
    for (int k = 0; k < 3; k++) begin
      w1.push_back(16'hE000 + 16'(k));
      exp_src.push_back(1); exp_dat.push_back(16'hE000 + 16'(k));
    end
    run(40, 1'b0, "T3");
    cmp_log("T3");
    check("T3 no write while full", 32'(wr_full), 32'd0);
    check("T3 stall wr", 32'(wr_log[3]), 32'd0);
    check("T3 stall gnt", 32'(gnt_log[3]), 32'h2);
    check("T3 err", 32'(a_err), 32'd0);
    if (lg_cyc.size() == 3) begin
      check("T3 write1 cycle", 32'(lg_cyc[0]), 32'd1);
      check("T3 write2 cycle", 32'(lg_cyc[1]), 32'd6);
      check("T3 write3 cycle", 32'(lg_cyc[2]), 32'd7);
    end else begin
      check("T3 write cycles", 32'(lg_cyc.size()), 32'd3);
    end

    // T4: p1 burst interrupted by reset after its 2nd word (rr was 1).
    setup();
    w0.push_back(16'h00F0);
    for (int k = 0; k < 4; k++) w1.push_back(16'h0B10 + 16'(k));
    rst_cyc = 5;
    run(6, 1'b1, "T4a");
    check("T4 words before rst", 32'(lg_dat.size()), 32'd3);
    check("T4 rst cycle wr", 32'(wr_log[5]), 32'd0);
    check("T4 rst cycle gnt", 32'(gnt_log[5]), 32'h2);
    clear_log();
    rst_cyc = -1;
    w0.push_back(16'h00F1); w0.push_back(16'h00F2);
    exp_src = '{0, 0, 1, 1};
    exp_dat = '{16'h00F1, 16'h00F2, 16'h0B12, 16'h0B13};
    run(40, 1'b0, "T4b");
    check("T4 gnt after rst", 32'(gnt_log[0]), 32'h0);
    check("T4 rr0 wins", 32'(gnt_log[1]), 32'h1);
    cmp_log("T4");

    // T5: MAX_BURST=1 instance, both producers continuous: strict alternation.
    setup();
    sel = 1;
    auto_pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w0.push_back(16'h5000 + 16'(k));
      w1.push_back(16'h6000 + 16'(k));
      exp_src.push_back(0); exp_dat.push_back(16'h5000 + 16'(k));
      exp_src.push_back(1); exp_dat.push_back(16'h6000 + 16'(k));
    end
    run(40, 1'b0, "T5");
    cmp_log("T5");
    check("T5 ack0&ack1 never", 32'(both_ack), 32'd0);
`ifdef ARB_STATS_EN
    check("T5 wcnt0", 32'(b_wc0), 32'd4);
    check("T5 wcnt diff", 32'((b_wc0 > b_wc1 ? b_wc0 - b_wc1 : b_wc1 - b_wc0) <= 16'd1), 32'd1);
`endif

    // T6: one-cycle overflow pulse during G0 sets a sticky err.
    do_reset();
    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; din0 = 16'h7000; fifo_full = 1'b1;
    @(negedge clk);
    fifo_over = 1'b1;
    #1;
    check("T6 gnt", 32'(a_gnt), 32'h1);
    check("T6 err before", 32'(a_err), 32'd0);
    @(negedge clk);
    fifo_over = 1'b0;
    #1;
    check("T6 err set", 32'(a_err), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("T6 err holds", 32'(a_err), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0; fifo_full = 1'b0;
    #1;
    check("T6 err cleared by rst", 32'(a_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
